// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the operands LSB first,
// one bit per cycle, producing {cout, z} = a + b + cin after WIDTH cycles in RUN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Partial sum holds the WIDTH-1 bits already produced; the last bit comes straight
  // from the adder cell on the completing edge.
  logic [WIDTH-2:0] zsh_q, zsh_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  count_q, count_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_cat;

  // Single full-adder cell on the current LSBs and the carry flop.
  assign fa_sum   = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign fa_carry = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
  assign sum_cat  = {fa_sum, zsh_q};

  // Next-state and datapath update; operands are accepted from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zsh_d   = zsh_q;
    z_d     = z_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    count_d = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          count_d = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        zsh_d   = sum_cat[WIDTH-1:1];
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_carry;
        count_d = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          z_d     = sum_cat;
          cout_d  = fa_carry;
          count_d = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      zsh_q   <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zsh_q   <= zsh_d;
      z_q     <= z_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      count_q <= count_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign z    = z_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 instance checked every cycle against a
// cycle-count/arithmetic model, plus directed cases and a WIDTH=2 exhaustive sweep.
module tb_serial_adder;

  localparam int W8 = 8;
  localparam int W2 = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start8 = 1'b0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          cin8 = 1'b0;
  logic          busy8, done8, cout8;
  logic [W8-1:0] z8;

  logic          start2 = 1'b0;
  logic [W2-1:0] a2 = '0, b2 = '0;
  logic          cin2 = 1'b0;
  logic          busy2, done2, cout2;
  logic [W2-1:0] z2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .z(z8), .cout(cout8)
  );

  serial_adder #(.WIDTH(W2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .z(z2), .cout(cout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_k counts edges since the accepting edge (-1 = nothing in flight).
  // The result is plain a+b+cin and appears WIDTH edges after acceptance.
  int         m_k = -1;
  logic [8:0] m_res = '0;
  logic [8:0] m_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_k   = -1;
      m_res = '0;
    end else if ((m_k < 0 || m_k == W8) && start8) begin
      m_k    = 0;
      m_pend = 9'(a8) + 9'(b8) + 9'(cin8);
    end else if (m_k >= 0 && m_k < W8) begin
      m_k++;
      if (m_k == W8) m_res = m_pend;
    end else begin
      m_k = -1;
    end
  end

  // Per-cycle comparison of the WIDTH=8 instance against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_busy", 32'(busy8), 32'(m_k >= 0 && m_k < W8));
    chk("cyc_done", 32'(done8), 32'(m_k == W8));
    chk("cyc_z", 32'(z8), 32'(m_res[7:0]));
    chk("cyc_cout", 32'(cout8), 32'(m_res[8]));
  end

  task automatic wait_done8(output int nb, output bit got);
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < W8 + 4; i++) begin
      if (done8 === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy8 === 1'b1) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      output int nb, output bit got);
    @(negedge clk);
    start8 = 1'b1; a8 = ai; b8 = bi; cin8 = ci;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(nb, got);
  endtask

  initial begin
    int  nb, ndone, t1, t2, err0;
    bit  got;
    int  exp2;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy8), 32'h0);
    chk("rst_done", 32'(done8), 32'h0);
    chk("rst_z", 32'(z8), 32'h0);
    chk("rst_cout", 32'(cout8), 32'h0);

    // 0F + 01
    run8(8'h0F, 8'h01, 1'b0, nb, got);
    chk("t1_done_seen", 32'(got), 32'h1);
    chk("t1_busy_cycles", 32'(nb), 32'd8);
    chk("t1_z", 32'(z8), 32'h10);
    chk("t1_cout", 32'(cout8), 32'h0);
    chk("t1_model", 32'(m_res), 32'h010);

    // Full carry ripple
    run8(8'hFF, 8'h01, 1'b0, nb, got);
    chk("t2a_done_seen", 32'(got), 32'h1);
    chk("t2a_z", 32'(z8), 32'h00);
    chk("t2a_cout", 32'(cout8), 32'h1);
    run8(8'hFF, 8'hFF, 1'b1, nb, got);
    chk("t2b_done_seen", 32'(got), 32'h1);
    chk("t2b_z", 32'(z8), 32'hFF);
    chk("t2b_cout", 32'(cout8), 32'h1);
    chk("t2b_model", 32'(m_res), 32'h1FF);

    // start while busy is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    repeat (14) begin
      if (done8 === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("t3_done_count", 32'(ndone), 32'd1);
    chk("t3_z", 32'(z8), 32'h46);
    chk("t3_cout", 32'(cout8), 32'h0);

    // Reset mid-operation abandons the add
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_busy", 32'(busy8), 32'h0);
    chk("t4_done", 32'(done8), 32'h0);
    chk("t4_z", 32'(z8), 32'h0);
    chk("t4_cout", 32'(cout8), 32'h0);
    ndone = 0;
    repeat (12) begin
      if (done8 === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("t4_no_done", 32'(ndone), 32'd0);

    // Back-to-back: new start during done
    run8(8'h3C, 8'h0A, 1'b1, nb, got);
    chk("t5_first_done", 32'(got), 32'h1);
    chk("t5_first_z", 32'(z8), 32'h47);
    t1 = cyc;
    start8 = 1'b1; a8 = 8'h81; b8 = 8'h7F; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    chk("t5_busy_next", 32'(busy8), 32'h1);
    wait_done8(nb, got);
    t2 = cyc;
    chk("t5_second_done", 32'(got), 32'h1);
    chk("t5_interval", 32'(t2 - t1), 32'(W8 + 1));
    chk("t5_busy_cycles", 32'(nb), 32'd8);
    chk("t5_z", 32'(z8), 32'h00);
    chk("t5_cout", 32'(cout8), 32'h1);

    // Randomized traffic with occasional resets and starts while busy
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 99) == 0);
      start8 = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       a8 = 8'hFF;
        1:       a8 = 8'h00;
        default: a8 = 8'($urandom);
      endcase
      b8   = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset  = 1'b0;
    start8 = 1'b0;
    repeat (W8 + 3) @(negedge clk);

    // WIDTH=2 exhaustive sweep
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          err0 = errors;
          @(negedge clk);
          start2 = 1'b1; a2 = 2'(ai); b2 = 2'(bi); cin2 = 1'(ci);
          @(negedge clk);
          start2 = 1'b0;
          nb  = 0;
          got = 1'b0;
          for (int i = 0; i < 8; i++) begin
            if (done2 === 1'b1) begin
              got = 1'b1;
              break;
            end
            if (busy2 === 1'b1) nb++;
            @(negedge clk);
          end
          exp2 = ai + bi + ci;
          chk("w2_done_seen", 32'(got), 32'h1);
          chk("w2_busy_cycles", 32'(nb), 32'd2);
          chk("w2_sum", 32'({cout2, z2}), 32'(exp2));
          if (errors == err0) $display("PASS w2 %0d+%0d+%0d = %0d", ai, bi, ci, exp2);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
